// File: rtl/cycle_sequencer_pkg.sv
// Shared definitions for the machine-cycle sequencer and the control decoder:
// timing-state encodings, execute-length codes and the default watchdog limit.
package cycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF1  = 3'd1,
        ST_IF2  = 3'd2,
        ST_EX1  = 3'd3,
        ST_EX2  = 3'd4,
        ST_EX3  = 3'd5,
        ST_EX4  = 3'd6
    } state_e;

    // ex_len carries the number of execute beats minus one
    localparam logic [1:0] EXLEN_1 = 2'd0;
    localparam logic [1:0] EXLEN_2 = 2'd1;
    localparam logic [1:0] EXLEN_3 = 2'd2;
    localparam logic [1:0] EXLEN_4 = 2'd3;

    localparam int DEFAULT_TIMEOUT = 16;

    function automatic logic is_wait_state(input state_e s);
        is_wait_state = (s == ST_IF2) || (s == ST_EX1) || (s == ST_EX2) ||
                        (s == ST_EX3) || (s == ST_EX4);
    endfunction

    function automatic state_e last_ex_state(input logic [1:0] len);
        last_ex_state = ST_EX4;
        case (len)
            EXLEN_1: last_ex_state = ST_EX1;
            EXLEN_2: last_ex_state = ST_EX2;
            EXLEN_3: last_ex_state = ST_EX3;
            EXLEN_4: last_ex_state = ST_EX4;
        endcase
    endfunction

    function automatic state_e next_ex_state(input state_e s);
        next_ex_state = ST_EX4;
        case (s)
            ST_EX1:  next_ex_state = ST_EX2;
            ST_EX2:  next_ex_state = ST_EX3;
            default: next_ex_state = ST_EX4;
        endcase
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Wait-state watchdog: counts cycles a wait state is held and flags expiry
// once the count reaches TIMEOUT-1.
module seq_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !hold) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/cycle_sequencer.sv
// Machine-cycle / timing-state generator: walks IF1, IF2, EX1..EXn per instruction,
// with run/halt control, a bus-wait watchdog and a retired-instruction counter.
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             output_done,
    input  logic [1:0]       ex_len,
    output logic             Mif,
    output logic             Mex,
    output logic             T1_Mif,
    output logic             T2_Mif,
    output logic             T1,
    output logic             T2,
    output logic             T3,
    output logic             T4,
    output logic [2:0]       cur_state,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retired_cnt
);

    state_e           state_q, state_d, prev_q;
    logic [1:0]       len_q, len_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wd_expired;
    logic             entry;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (run && !err_q) state_d = ST_IF1;
            ST_IF1:  state_d = ST_IF2;
            ST_IF2: begin
                if (output_done) begin
                    state_d = ST_EX1;
                    len_d   = ex_len;
                end
            end
            default: begin
                if (output_done) begin
                    if (state_q == last_ex_state(len_q)) begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = run ? ST_IF1 : ST_IDLE;
                    end else begin
                        state_d = next_ex_state(state_q);
                    end
                end
            end
        endcase
        // A step completing on the expiry cycle takes precedence over the watchdog
        if (is_wait_state(state_q) && !output_done && wd_expired) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            prev_q  <= ST_IDLE;
            len_q   <= EXLEN_1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= state_q;
            len_q   <= len_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .hold    (is_wait_state(state_q)),
        .expired (wd_expired)
    );

    // Strobes fire only on the first cycle of a state, so a held state never re-requests the bus
    assign entry = (state_q != prev_q);

    assign T1_Mif      = entry && (state_q == ST_IF1);
    assign T2_Mif      = entry && (state_q == ST_IF2);
    assign T1          = entry && (state_q == ST_EX1);
    assign T2          = entry && (state_q == ST_EX2);
    assign T3          = entry && (state_q == ST_EX3);
    assign T4          = entry && (state_q == ST_EX4);
    assign Mif         = (state_q == ST_IF1) || (state_q == ST_IF2);
    assign Mex         = (state_q == ST_EX1) || (state_q == ST_EX2) ||
                         (state_q == ST_EX3) || (state_q == ST_EX4);
    assign cur_state   = state_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = err_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: a cycle-level behavioural model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_cycle_sequencer;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             output_done;
    logic [1:0]       ex_len;
    logic             Mif, Mex, T1_Mif, T2_Mif, T1, T2, T3, T4;
    logic [2:0]       cur_state;
    logic             busy, timeout_err;
    logic [CNT_W-1:0] retired_cnt;

    int checks   = 0;
    int failures = 0;

    cycle_sequencer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .output_done (output_done),
        .ex_len      (ex_len),
        .Mif         (Mif),
        .Mex         (Mex),
        .T1_Mif      (T1_Mif),
        .T2_Mif      (T2_Mif),
        .T1          (T1),
        .T2          (T2),
        .T3          (T3),
        .T4          (T4),
        .cur_state   (cur_state),
        .busy        (busy),
        .timeout_err (timeout_err),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Model phases: 0 idle, 1 fetch beat 1, 2 fetch beat 2, 3+k execute beat k
    int m_state, m_wait, m_len, m_cnt;
    bit m_err, m_entry;

    always @(posedge clk or posedge rst) begin : model_step
        int nxt;
        if (rst) begin
            m_state = 0; m_wait = 0; m_len = 0; m_cnt = 0; m_err = 0; m_entry = 0;
        end else begin
            nxt = m_state;
            if (m_state == 0) begin
                if (run && !m_err) nxt = 1;
            end else if (m_state == 1) begin
                nxt = 2;
            end else if (output_done) begin
                if (m_state == 2) begin
                    nxt   = 3;
                    m_len = int'(ex_len);
                end else if (m_state - 3 == m_len) begin
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    nxt   = run ? 1 : 0;
                end else begin
                    nxt = m_state + 1;
                end
            end else if (m_wait == TIMEOUT - 1) begin
                nxt   = 0;
                m_err = 1;
            end
            m_entry = (nxt != m_state);
            m_wait  = (nxt != m_state || m_state < 2) ? 0 : m_wait + 1;
            m_state = nxt;
        end
    end

    always @(negedge clk) begin : compare
        logic [16:0] exp_v, act_v;
        if (rst === 1'b0) begin
            exp_v = {m_state == 1 || m_state == 2, m_state >= 3,
                     m_entry && m_state == 1, m_entry && m_state == 2,
                     m_entry && m_state == 3, m_entry && m_state == 4,
                     m_entry && m_state == 5, m_entry && m_state == 6,
                     m_state != 0, m_err, 3'(m_state), 4'(m_cnt)};
            act_v = {Mif, Mex, T1_Mif, T2_Mif, T1, T2, T3, T4,
                     busy, timeout_err, cur_state, retired_cnt};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_model t=%0t: got %h expected %h", $time, act_v, exp_v);
            end
        end
    end

    initial begin
        rst = 1'b1; run = 1'b1; ex_len = 2'd0; output_done = 1'b0;
        #3;
        check("reset_state", 32'(cur_state), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_err", 32'(timeout_err), 0);
        check("reset_cnt", 32'(retired_cnt), 0);
        check("reset_strobe", 32'({T1_Mif, T2_Mif, T1, T2, T3, T4}), 0);

        // First instruction: 1-beat execute, output_done on the third IF2 cycle
        tick(); rst = 1'b0;
        tick(); check("if1_state", 32'(cur_state), 1); check("if1_strobe", 32'(T1_Mif), 1);
        tick(); check("if2_state", 32'(cur_state), 2); check("if2_strobe", 32'(T2_Mif), 1);
        tick(); check("if2_held_nostrobe", 32'(T2_Mif), 0);
        tick(); check("if2_third", 32'(cur_state), 2); output_done = 1'b1;
        tick(); check("ex1_state", 32'(cur_state), 3); check("ex1_strobe", 32'(T1), 1);
                check("ex1_phase", 32'({Mif, Mex}), 1);
        tick(); check("b2b_if1", 32'(cur_state), 1); check("retire1", 32'(retired_cnt), 1);

        // LW: 3 beats, EX2 held for 6 cycles, ex_len changed after latching
        ex_len = 2'd2;
        tick();
        tick(); check("lw_ex1", 32'(cur_state), 3);
        tick(); check("lw_ex2", 32'(cur_state), 4); check("lw_t2", 32'(T2), 1); output_done = 1'b0;
        tick(); check("lw_ex2_held", 32'(T2), 0); ex_len = 2'd0;
        repeat (3) tick();
        tick(); check("lw_ex2_last", 32'(cur_state), 4); output_done = 1'b1;
        tick(); check("lw_ex3", 32'(cur_state), 5); check("lw_t3", 32'(T3), 1);
        tick(); check("lw_retire_if1", 32'(cur_state), 1); check("retire2", 32'(retired_cnt), 2);

        // SW with run dropped during EX2
        ex_len = 2'd1;
        tick();
        tick();
        tick(); check("sw_ex2", 32'(cur_state), 4); run = 1'b0; output_done = 1'b0;
        tick(); output_done = 1'b1;
        tick(); check("halt_idle", 32'(cur_state), 0); check("halt_busy", 32'(busy), 0);
                check("halt_cnt", 32'(retired_cnt), 3);
        tick();
        tick(); check("halt_stays", 32'(cur_state), 0); run = 1'b1;
        tick(); check("resume_if1", 32'(cur_state), 1); output_done = 1'b0;

        // Watchdog: output_done held low in IF2
        tick(); check("wd_if2", 32'(cur_state), 2);
        repeat (15) tick();
        check("wd_if2_16th", 32'(cur_state), 2);
        tick(); check("wd_idle", 32'(cur_state), 0); check("wd_err", 32'(timeout_err), 1);
        tick();
        tick(); check("wd_blocks_run", 32'(cur_state), 0); check("wd_sticky", 32'(timeout_err), 1);
        #2 rst = 1'b1;
        #1 check("wd_rst_clears", 32'(timeout_err), 0);

        // Boundary: output_done on the expiry cycle wins
        tick(); rst = 1'b0;
        tick(); check("bd_if1", 32'(cur_state), 1); ex_len = 2'd3; output_done = 1'b0;
        tick();
        repeat (15) tick();
        check("bd_if2_16th", 32'(cur_state), 2); output_done = 1'b1;
        tick(); check("bd_ex1", 32'(cur_state), 3); check("bd_no_err", 32'(timeout_err), 0);
        tick();
        tick(); check("ar_ex3", 32'(cur_state), 5);

        // Asynchronous reset mid-EX3, sampled before any clock edge
        #2 rst = 1'b1;
        #1 check("async_rst_all", 32'({Mif, Mex, T1_Mif, T2_Mif, T1, T2, T3, T4,
                                          busy, timeout_err, cur_state, retired_cnt}), 0);

        // Counter wrap: 4-beat instructions back to back
        tick(); rst = 1'b0;
        tick(); check("wr_if1", 32'(cur_state), 1);
        repeat (5) tick();
        check("wr_ex4", 32'(cur_state), 6); check("wr_t4", 32'(T4), 1);
        tick(); check("wr_cnt1", 32'(retired_cnt), 1);
        repeat (84) tick();
        check("wr_cnt15", 32'(retired_cnt), 15);
        repeat (6) tick();
        check("wr_cnt_wrap", 32'(retired_cnt), 0); check("wr_wrap_if1", 32'(cur_state), 1);

        run = 1'b0;
        repeat (8) tick();
        check("final_idle", 32'(cur_state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
